// File: rtl/mem_access_unit.sv
// Load/store initiator: one CPU access in, one word-wide memory request out, one response back.
// Latency: error 1 cycle, store 2 cycles, load 3 cycles from accept (no stalls); one access in flight.
// Backpressure: req_ready only in IDLE; mem_req held until mem_gnt; resp_valid held until resp_ready.
module mem_access_unit #(
    parameter int unsigned DM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_signed,
    input  logic [2:0]  req_bytes,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state;
    logic        we_q;
    logic        signed_q;
    logic [2:0]  bytes_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        size_ok;
    logic        align_ok;
    logic        range_ok;
    logic        req_err;
    logic [32:0] limit;

    // 33-bit compare so addresses near 2^32 cannot wrap into range
    always_comb begin
        size_ok  = (req_bytes == 3'd1) || (req_bytes == 3'd2) || (req_bytes == 3'd4);
        align_ok = !(((req_bytes == 3'd2) && req_addr[0]) ||
                     ((req_bytes == 3'd4) && (req_addr[1:0] != 2'b00)));
        limit    = 33'(DM_BYTES) - {30'd0, req_bytes};
        range_ok = ({1'b0, req_addr} <= limit);
        req_err  = !(size_ok && align_ok && range_ok);
    end

    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;

    always_comb begin
        case (bytes_q)
            3'd1: begin
                be_c = 4'b0001 << addr_q[1:0];
                wd_c = {4{wdata_q[7:0]}};
            end
            3'd2: begin
                be_c = 4'b0011 << addr_q[1:0];
                wd_c = {2{wdata_q[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = wdata_q;
            end
        endcase
    end

    // halfword accesses are always 2-byte aligned here, so addr[1] picks the half
    always_comb begin
        byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (bytes_q)
            3'd1:    ld_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
            3'd2:    ld_data = {{16{signed_q & half_sel[15]}}, half_sel};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            bytes_q  <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        bytes_q  <= req_bytes;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'd0;
                        err_q    <= req_err;
                        state    <= req_err ? RESP : REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state <= we_q ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= ld_data;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // memory-side outputs are driven only while the request is on the bus
    always_comb begin
        req_ready  = (state == IDLE);
        mem_req    = (state == REQ);
        mem_we     = mem_req & we_q;
        mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_be     = mem_req ? be_c : 4'b0000;
        mem_wdata  = mem_req ? wd_c : 32'd0;
        resp_valid = (state == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses, a memory responder and a response scoreboard.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_signed;
    logic [2:0]  req_bytes;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    mem_access_unit #(.DM_BYTES(4096)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_signed(req_signed), .req_bytes(req_bytes), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc_cyc;
        int          ready_wait;
    } resp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_wait;
        bit          bogus;
        bit          abort;
    } mem_exp_t;

    resp_exp_t rq[$];
    mem_exp_t  mq[$];
    resp_exp_t mon_e;
    mem_exp_t  mem_m;
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // response monitor / scoreboard, also owns resp_ready
    initial begin : monitor
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && resp_valid) begin
                if (rq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_unexpected: got resp_valid=1 expected 0");
                end else begin
                    mon_e = rq.pop_front();
                    chk("resp_err", 32'(resp_err), 32'(mon_e.err));
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
                    repeat (mon_e.ready_wait) begin
                        @(negedge clk);
                        chk("resp_valid_hold", 32'(resp_valid), 32'd1);
                        chk("resp_rdata_hold", resp_rdata, mon_e.rdata);
                        chk("resp_err_hold", 32'(resp_err), 32'(mon_e.err));
                        chk("req_ready_busy", 32'(req_ready), 32'd0);
                    end
                end
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
            end
        end
    end

    // memory responder: checks the request, grants after gnt_wait, returns read data
    initial begin : memory
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (reset && mem_req) begin
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_req_unexpected: got mem_req=1 expected 0");
                    mem_m.we    = 1'b1;
                    mem_m.abort = 1'b0;
                    mem_gnt     = 1'b1;
                end else begin
                    mem_m = mq.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(mem_m.we));
                    chk("mem_addr", mem_addr, mem_m.addr);
                    chk("mem_be", 32'(mem_be), 32'(mem_m.be));
                    chk("mem_wdata", mem_wdata, mem_m.wdata);
                    repeat (mem_m.gnt_wait) begin
                        @(negedge clk);
                        chk("mem_req_hold", 32'(mem_req), 32'd1);
                        chk("mem_addr_hold", mem_addr, mem_m.addr);
                        chk("mem_be_hold", 32'(mem_be), 32'(mem_m.be));
                        chk("mem_wdata_hold", mem_wdata, mem_m.wdata);
                        chk("req_ready_stall", 32'(req_ready), 32'd0);
                    end
                    mem_gnt = 1'b1;
                    if (mem_m.bogus) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = 32'h1111_1111;
                    end
                end
                @(negedge clk);
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'd0;
                if (!mem_m.we) begin
                    if (mem_m.abort) repeat (2) @(negedge clk);
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_m.rdata;
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                    mem_rdata  = 32'd0;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic sgn, input logic [2:0] bytes,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gw, input int rw,
                         input bit bogus, input bit abort, input logic err,
                         input logic [31:0] exp_rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_maddr, input logic [31:0] exp_wd,
                         input int lat);
        int n;
        resp_exp_t e;
        mem_exp_t  m;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_signed = sgn;
        req_bytes  = bytes;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_accept_timeout: got req_ready=0 expected 1");
            req_valid = 1'b0;
            return;
        end
        if (!abort) begin
            e.err        = err;
            e.rdata      = exp_rd;
            e.lat        = lat;
            e.acc_cyc    = cyc;
            e.ready_wait = rw;
            rq.push_back(e);
        end
        if (!err) begin
            m.we       = we;
            m.addr     = exp_maddr;
            m.be       = exp_be;
            m.wdata    = exp_wd;
            m.rdata    = rdata;
            m.gnt_wait = gw;
            m.bogus    = bogus;
            m.abort    = abort;
            mq.push_back(m);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_signed = 1'b0;
        req_bytes  = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b1;

        //    we  sg bytes addr          wdata         rdata         gw rw bg ab err exp_rd        be       maddr         mwdata        lat
        issue(1, 0, 3'd1, 32'h0000_0006, 32'h1234_56AB, 32'h0,        0, 0, 0, 0, 0, 32'h0,        4'b0100, 32'h0000_0004, 32'hABAB_ABAB, 2);
        issue(0, 1, 3'd2, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 0, 0, 0, 0, 32'hFFFF_8001, 4'b1100, 32'h0,        32'h0,        3);
        issue(0, 0, 3'd2, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 0, 0, 0, 0, 32'h0000_8001, 4'b1100, 32'h0,        32'h0,        3);
        issue(0, 1, 3'd1, 32'h0000_0001, 32'h0,        32'h0000_F000, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 4'b0010, 32'h0,        32'h0,        3);
        issue(0, 1, 3'd4, 32'h0000_0008, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0008, 32'h0,        3);
        issue(0, 0, 3'd4, 32'h0000_0002, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        32'h0,        1);
        issue(0, 0, 3'd2, 32'h0000_0003, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        32'h0,        1);
        issue(0, 0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        32'h0,        1);
        issue(0, 0, 3'd4, 32'h0000_0FFE, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        32'h0,        1);
        issue(0, 0, 3'd4, 32'h0000_1000, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        32'h0,        1);
        issue(1, 0, 3'd1, 32'h0000_1000, 32'h0000_00FF, 32'h0,        0, 1, 0, 0, 1, 32'h0,        4'b0,    32'h0,        32'h0,        1);
        issue(0, 0, 3'd1, 32'hFFFF_FFFF, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        32'h0,        1);
        issue(0, 0, 3'd0, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        4'b0,    32'h0,        32'h0,        1);
        issue(1, 0, 3'd2, 32'h0000_0002, 32'hAAAA_BEEF, 32'h0,        3, 2, 0, 0, 0, 32'h0,        4'b1100, 32'h0,        32'hBEEF_BEEF, 5);
        issue(0, 0, 3'd1, 32'h0000_0003, 32'h0,        32'h9A00_0000, 0, 0, 1, 0, 0, 32'h0000_009A, 4'b1000, 32'h0,        32'h0,        3);
        issue(1, 0, 3'd4, 32'h0000_0FFC, 32'h0123_4567, 32'h0,        0, 0, 0, 0, 0, 32'h0,        4'b1111, 32'h0000_0FFC, 32'h0123_4567, 2);
        issue(0, 1, 3'd2, 32'h0000_0FFE, 32'h0,        32'h7FFF_0000, 0, 0, 0, 0, 0, 32'h0000_7FFF, 4'b1100, 32'h0000_0FFC, 32'h0,        3);
        issue(1, 0, 3'd1, 32'h0000_0FFF, 32'h0000_0055, 32'h0,        0, 0, 0, 0, 0, 32'h0,        4'b1000, 32'h0000_0FFC, 32'h5555_5555, 2);
        issue(0, 1, 3'd1, 32'h0000_0FFF, 32'h0,        32'h8000_0000, 0, 1, 0, 0, 0, 32'hFFFF_FF80, 4'b1000, 32'h0000_0FFC, 32'h0,        3);

        // reset while the load sits in WAIT; the late read data must be dropped
        issue(0, 0, 3'd4, 32'h0000_0010, 32'h0,        32'h5A5A_5A5A, 0, 0, 0, 1, 0, 32'h0,        4'b1111, 32'h0000_0010, 32'h0,        3);
        @(negedge clk);
        chk("wait_mem_req", 32'(mem_req), 32'd0);
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        end

        issue(0, 0, 3'd4, 32'h0000_0020, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 4'b1111, 32'h0000_0020, 32'h0,        3);

        n = 0;
        while ((rq.size() != 0 || mq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rq.size() != 0 || mq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d resp %0d mem pending expected 0", rq.size(), mq.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
